// File: rtl/fetch_queue_pkg.sv
// Constants shared by the fetch, queue and decode stages.
package fetch_queue_pkg;
  localparam int          XLEN     = 32;
  localparam logic [31:0] NOP_INST = 32'h0000_0013; // addi x0,x0,0
endpackage : fetch_queue_pkg

// File: rtl/fetch_queue.sv
// First-word-fall-through queue of {pc, inst} pairs between fetch and decode.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int N     = XLEN,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [N-1:0]               in_pc,
  input  logic [N-1:0]               in_inst,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [N-1:0]               out_pc,
  output logic [N-1:0]               out_inst,
  input  logic                       out_ready,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [2*N-1:0] r_mem [DEPTH];
  logic [PW-1:0]  r_rd_ptr;
  logic [PW-1:0]  r_wr_ptr;
  logic [CW-1:0]  r_count;

  logic           w_push;
  logic           w_pop;
  logic [2*N-1:0] w_head;

  assign in_ready  = (r_count < CW'(DEPTH));
  assign out_valid = (r_count != '0);
  assign count     = r_count;

  // flush outranks both push and pop; an empty queue never pops
  assign w_push = in_valid && in_ready && !flush;
  assign w_pop  = out_valid && out_ready && !flush;

  // Storage is left uncleared by reset; out_valid masks stale entries.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {in_pc, in_inst};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_head   = r_mem[r_rd_ptr];
  assign out_pc   = out_valid ? w_head[2*N-1:N] : '0;
  assign out_inst = out_valid ? w_head[N-1:0]   : N'(NOP_INST);

endmodule : fetch_queue

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: a reference queue predicts every output.
module tb_fetch_queue;
  localparam int N     = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [N-1:0]  in_pc;
  logic [N-1:0]  in_inst;
  logic          in_ready;
  logic          out_valid;
  logic [N-1:0]  out_pc;
  logic [N-1:0]  out_inst;
  logic          out_ready;
  logic          flush;
  logic [CW-1:0] count;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] sb_q[$];

  always #5 clk = ~clk;

  fetch_queue #(.N(N), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_pc     (in_pc),
    .in_inst   (in_inst),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_inst  (out_inst),
    .out_ready (out_ready),
    .flush     (flush),
    .count     (count)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_outputs(input string tag);
    int sz;
    sz = sb_q.size();
    chk({tag, ":count"},     64'(count),     64'(sz));
    chk({tag, ":in_ready"},  64'(in_ready),  64'(sz < DEPTH));
    chk({tag, ":out_valid"}, 64'(out_valid), 64'(sz != 0));
    if (sz != 0) begin
      chk({tag, ":out_pc"},   64'(out_pc),   64'(sb_q[0][63:32]));
      chk({tag, ":out_inst"}, 64'(out_inst), 64'(sb_q[0][31:0]));
    end else begin
      chk({tag, ":out_pc"},   64'(out_pc),   64'd0);
      chk({tag, ":out_inst"}, 64'(out_inst), 64'(NOP));
    end
  endtask

  // Drive one cycle, check current outputs against the model, then clock it.
  task automatic do_cycle(input string tag, input logic v, input logic [31:0] pc,
                          input logic [31:0] inst, input logic ordy, input logic fl);
    logic m_push, m_pop;
    in_valid  = v;
    in_pc     = pc;
    in_inst   = inst;
    out_ready = ordy;
    flush     = fl;
    #1;
    chk_outputs(tag);
    m_push = v && (sb_q.size() < DEPTH) && !fl;
    m_pop  = (sb_q.size() != 0) && ordy && !fl;
    if (fl) begin
      sb_q.delete();
      $display("[%0t] %s flush", $time, tag);
    end else begin
      if (m_pop) begin
        $display("[%0t] %s pop  pc=%h inst=%h", $time, tag, out_pc, out_inst);
        void'(sb_q.pop_front());
      end
      if (m_push) begin
        sb_q.push_back({pc, inst});
        $display("[%0t] %s push pc=%h inst=%h", $time, tag, pc, inst);
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {pc[15:0], 16'h0093} ^ 32'h5A00_0000;
  endfunction

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_pc = '0; in_inst = '0;
    out_ready = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_outputs("reset");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // single push, visible next cycle, then drained
    do_cycle("single", 1'b1, 32'h0, 32'h0050_0093, 1'b0, 1'b0);
    chk("single:inst", 64'(out_inst), 64'h0050_0093);
    do_cycle("drain1", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // fill to full, fifth push ignored, drain in order
    for (int i = 0; i < 5; i++)
      do_cycle("fill", 1'b1, 32'(i * 4), inst_of(32'(i * 4)), 1'b0, 1'b0);
    chk("full:in_ready", 64'(in_ready), 64'd0);
    for (int i = 0; i < 5; i++)
      do_cycle("drain", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // streaming: push+pop every cycle, pointers wrap past DEPTH
    for (int i = 0; i < 10; i++)
      do_cycle("stream", 1'b1, 32'(i * 4), inst_of(32'(i * 4)), 1'b1, 1'b0);
    do_cycle("stream_end", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // flush with three queued and a concurrent push
    for (int i = 0; i < 3; i++)
      do_cycle("prefl", 1'b1, 32'h100 + 32'(i * 4), inst_of(32'h100 + 32'(i * 4)), 1'b0, 1'b0);
    do_cycle("flush", 1'b1, 32'h200, 32'h0000_00ff, 1'b1, 1'b1);
    do_cycle("postfl", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // asynchronous reset mid-cycle with two queued
    for (int i = 0; i < 2; i++)
      do_cycle("prerst", 1'b1, 32'h300 + 32'(i * 4), inst_of(32'h300 + 32'(i * 4)), 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    sb_q.delete();
    chk_outputs("async_rst");
    @(negedge clk);
    reset = 1'b1;
    do_cycle("rst_push", 1'b1, 32'h40, 32'h0040_0013, 1'b0, 1'b0);
    chk("rst_push:pc", 64'(out_pc), 64'h40);
    do_cycle("rst_drain", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // random traffic
    for (int i = 0; i < 80; i++) begin
      logic [31:0] pc;
      pc = 32'h1000 + 32'(i * 4);
      do_cycle("rand", 1'($urandom_range(0, 3) != 0), pc, $urandom,
               1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
    end
    for (int i = 0; i < DEPTH + 1; i++)
      do_cycle("final", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_fetch_queue
